// File: rtl/multicycle_memory_if.sv
// Request/response bundle between the multi-cycle CPU control path (master)
// and the variable-latency word memory (slave).
interface multicycle_memory_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] din;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] dout;
    logic                  mem_ready;
    logic                  busy;
    logic                  addr_err;

    modport master (
        output addr, din, mem_read, mem_write,
        input  dout, mem_ready, busy, addr_err
    );

    modport slave (
        input  addr, din, mem_read, mem_write,
        output dout, mem_ready, busy, addr_err
    );
endinterface

// File: rtl/multicycle_memory.sv
// Variable-latency word memory: latches one request, services it LATENCY
// cycles later, then pulses mem_ready for a single cycle before accepting more.
module multicycle_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_IDX_W = 8,
    parameter int LATENCY    = 3
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_memory_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_IDX_W-1:0]   req_idx;
    logic                    req_oor;
    logic                    req_write;
    logic [DATA_WIDTH-1:0]   req_din;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    mem_ready_q;
    logic                    busy_q;
    logic                    addr_err_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic request;
    logic misaligned;
    logic out_of_range;
    logic conflict;
    logic complete;
    logic mem_we;

    assign request      = bus.mem_read | bus.mem_write;
    assign misaligned   = (bus.addr[1:0] != 2'b00);
    assign out_of_range = (bus.addr[31:ADDR_IDX_W+2] != '0);
    assign conflict     = bus.mem_read & bus.mem_write;
    assign complete     = (state == BUSY) && (cnt == 4'd0);
    // Gated by state, so a reset during BUSY can never let a write through.
    assign mem_we       = complete && req_write && !req_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_idx     <= '0;
            req_oor     <= 1'b0;
            req_write   <= 1'b0;
            req_din     <= '0;
            dout_q      <= '0;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready_q <= 1'b0;
                    if (request) begin
                        req_idx   <= bus.addr[ADDR_IDX_W+1:2];
                        req_oor   <= out_of_range;
                        req_write <= bus.mem_write;
                        req_din   <= bus.din;
                        cnt       <= CNT_INIT;
                        busy_q    <= 1'b1;
                        state     <= BUSY;
                        if (misaligned || out_of_range || conflict) begin
                            addr_err_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!req_write) begin
                            dout_q <= req_oor ? '0 : mem[req_idx];
                        end
                        mem_ready_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    mem_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    mem_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_idx] <= req_din;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.busy      = busy_q;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_multicycle_memory.sv
// Directed bench for multicycle_memory: a LATENCY=3 instance for the main
// behaviour and a LATENCY=1 instance for minimum latency and throughput.
module tb_multicycle_memory;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   readyCount3 = 0;

    multicycle_memory_if #(.DATA_WIDTH(32)) bus3 ();
    multicycle_memory_if #(.DATA_WIDTH(32)) bus1 ();

    multicycle_memory #(
        .DATA_WIDTH(32), .MEM_DEPTH(256), .ADDR_IDX_W(8), .LATENCY(3)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    multicycle_memory #(
        .DATA_WIDTH(32), .MEM_DEPTH(256), .ADDR_IDX_W(8), .LATENCY(1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus3.mem_ready) readyCount3 <= readyCount3 + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input bit rd, input bit wr,
                                 input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.din = d;
        end else begin
            bus3.mem_read = rd; bus3.mem_write = wr; bus3.addr = a; bus3.din = d;
        end
    endtask

    function automatic logic getReady(input bit sel);
        return sel ? bus1.mem_ready : bus3.mem_ready;
    endfunction

    function automatic logic getBusy(input bit sel);
        return sel ? bus1.busy : bus3.busy;
    endfunction

    // One request: lat = edges from sampling edge to the edge that raises mem_ready.
    task automatic transact(input bit sel, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d,
                            output int lat, output int busyCycles);
        applyStimulus(sel, rd, wr, a, d);
        step(1);
        applyStimulus(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        busyCycles = 0;
        while (lat < 20) begin
            if (getBusy(sel)) busyCycles++;
            if (getReady(sel)) break;
            step(1);
            lat++;
        end
        step(1);
        if (getBusy(sel)) busyCycles++;
        checkOutput("readyOneCycle", 32'(getReady(sel)), 32'h0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        int bc;
        int c0;
        logic [8:0] pat;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(2);
        checkOutput("rstDout",  bus3.dout, 32'h0);
        checkOutput("rstReady", 32'(bus3.mem_ready), 32'h0);
        checkOutput("rstBusy",  32'(bus3.busy), 32'h0);
        checkOutput("rstErr",   32'(bus3.addr_err), 32'h0);
        reset = 1'b0;

        // Preload words 4, 12 and 3, then reset; array contents survive reset.
        transact(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, bc);
        checkOutput("wrLatency", 32'(lat), 32'd3);
        transact(1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, lat, bc);
        transact(1'b0, 1'b0, 1'b1, 32'h0C, 32'h11111111, lat, bc);
        doReset();

        transact(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, bc);
        checkOutput("rdLatency", 32'(lat), 32'd3);
        checkOutput("rdBusyCycles", 32'(bc), 32'd4);
        checkOutput("rdData", bus3.dout, 32'hDEADBEEF);
        checkOutput("rdErr", 32'(bus3.addr_err), 32'h0);

        transact(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, lat, bc);
        checkOutput("wr20Latency", 32'(lat), 32'd3);
        transact(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, bc);
        checkOutput("rawData", bus3.dout, 32'h12345678);
        checkOutput("rawErr", 32'(bus3.addr_err), 32'h0);

        // Held request: first read latched at 0x10, address switches to 0x30 while busy.
        c0 = readyCount3;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        step(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
        step(3);
        checkOutput("heldFirstReady", 32'(bus3.mem_ready), 32'h1);
        checkOutput("heldFirstData", bus3.dout, 32'hDEADBEEF);
        step(1);
        checkOutput("heldIdleGap", 32'(bus3.busy), 32'h0);
        step(1);
        checkOutput("heldSecondBusy", 32'(bus3.busy), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(3);
        checkOutput("heldSecondReady", 32'(bus3.mem_ready), 32'h1);
        checkOutput("heldSecondData", bus3.dout, 32'hCAFEF00D);
        step(1);
        checkOutput("heldPulseCount", 32'(readyCount3 - c0), 32'd2);

        // Misaligned and out of range read.
        transact(1'b0, 1'b1, 1'b0, 32'h402, 32'h0, lat, bc);
        checkOutput("oorLatency", 32'(lat), 32'd3);
        checkOutput("oorData", bus3.dout, 32'h0);
        checkOutput("oorErr", 32'(bus3.addr_err), 32'h1);
        transact(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, bc);
        checkOutput("errSticky", 32'(bus3.addr_err), 32'h1);
        checkOutput("afterOorData", bus3.dout, 32'hDEADBEEF);

        // Out-of-range write aliases word 4 if the range check is missing.
        transact(1'b0, 1'b0, 1'b1, 32'h410, 32'hBAD0BAD0, lat, bc);
        transact(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, bc);
        checkOutput("oorWrDropped", bus3.dout, 32'hDEADBEEF);

        doReset();
        checkOutput("errCleared", 32'(bus3.addr_err), 32'h0);

        // Read and write together: write wins, dout untouched.
        transact(1'b0, 1'b1, 1'b1, 32'h08, 32'hA5A5A5A5, lat, bc);
        checkOutput("conflictErr", 32'(bus3.addr_err), 32'h1);
        checkOutput("conflictDout", bus3.dout, 32'h0);
        doReset();
        transact(1'b0, 1'b1, 1'b0, 32'h08, 32'h0, lat, bc);
        checkOutput("conflictWord", bus3.dout, 32'hA5A5A5A5);
        checkOutput("conflictErrAfterRst", 32'(bus3.addr_err), 32'h0);

        transact(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, lat, bc);
        checkOutput("misalignData", bus3.dout, 32'hDEADBEEF);
        checkOutput("misalignErr", 32'(bus3.addr_err), 32'h1);

        // Reset in the middle of a write to word 3.
        c0 = readyCount3;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0C, 32'h1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1);
        checkOutput("abortBusyBefore", 32'(bus3.busy), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("abortDout", bus3.dout, 32'h0);
        checkOutput("abortReady", 32'(bus3.mem_ready), 32'h0);
        checkOutput("abortBusy", 32'(bus3.busy), 32'h0);
        checkOutput("abortErr", 32'(bus3.addr_err), 32'h0);
        #1;
        reset = 1'b0;
        step(6);
        checkOutput("abortNoPulse", 32'(readyCount3 - c0), 32'd0);
        transact(1'b0, 1'b1, 1'b0, 32'h0C, 32'h0, lat, bc);
        checkOutput("abortWordKept", bus3.dout, 32'h11111111);

        // LATENCY=1 instance.
        transact(1'b1, 1'b0, 1'b1, 32'h0, 32'h5A5A0001, lat, bc);
        transact(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, lat, bc);
        checkOutput("l1Latency", 32'(lat), 32'd1);
        checkOutput("l1BusyCycles", 32'(bc), 32'd2);
        checkOutput("l1Data", bus1.dout, 32'h5A5A0001);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1);
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            pat[i] = bus1.mem_ready;
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(4);
        checkOutput("l1Spacing", 32'(pat), 32'h049);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
